// File: rtl/mod_id_ex_register_pkg.sv
// -----------------------------------------------------------------------------
// mod_id_ex_register_pkg
// Shared definitions for the 18-bit pipeline control word: bit positions of
// every control field, multi-bit field widths and the all-zero bubble word.
// Imported by the control unit, the ID/EX register and the EX/MEM register.
// -----------------------------------------------------------------------------
package mod_id_ex_register_pkg;

   localparam int CTRL_W = 18;

   // Single-bit control positions, MSB first
   localparam int CTRL_REG_DST     = 17;
   localparam int CTRL_MEM_TO_REG  = 16;
   localparam int CTRL_MEM_READ    = 15;
   localparam int CTRL_BRANCH      = 14;
   localparam int CTRL_MEM_WRITE   = 13;
   localparam int CTRL_ALU_OP_HI   = 12;   // alu_op occupies 12..10
   localparam int CTRL_ALU_SRC     = 9;
   localparam int CTRL_REG_WRITE   = 8;
   localparam int CTRL_SHIFT_SRC   = 7;
   localparam int CTRL_JMP_SRC     = 6;
   localparam int CTRL_JRETURN_DST = 5;
   localparam int CTRL_EQ_OR_NE    = 4;
   localparam int CTRL_DATA_MASK_HI = 3;   // data_mask occupies 3..2
   localparam int CTRL_IS_UNSIGNED = 1;
   localparam int CTRL_JMP_OR_BRCH = 0;

   localparam int NB_ALU_OP = 3;
   localparam int NB_MASK   = 2;

   // A bubble carries no side effect anywhere downstream
   localparam logic [CTRL_W-1:0] BUBBLE = 18'b0;

endpackage

// File: rtl/mod_id_ex_register_hazard.sv
// -----------------------------------------------------------------------------
// mod_hazard_detect
// Purely combinational load-use hazard detector. Flags when the instruction
// in EX is a valid load whose destination (rt, never $0) is read by the
// instruction currently in decode.
// Ports:
//   i_ex_valid     EX slot holds a real instruction
//   i_ex_mem_read  EX instruction is a load
//   i_ex_rt_addr   load destination register
//   i_id_rs_addr   decode source register rs
//   i_id_rt_addr   decode source register rt
//   o_hazard       stall request
// -----------------------------------------------------------------------------
module mod_hazard_detect #(
   parameter int NB_ADDR = 5
) (
   input  logic               i_ex_valid,
   input  logic               i_ex_mem_read,
   input  logic [NB_ADDR-1:0] i_ex_rt_addr,
   input  logic [NB_ADDR-1:0] i_id_rs_addr,
   input  logic [NB_ADDR-1:0] i_id_rt_addr,
   output logic               o_hazard
);

   logic dst_nonzero;
   logic addr_match;

   assign dst_nonzero = (i_ex_rt_addr != '0);
   assign addr_match  = (i_ex_rt_addr == i_id_rs_addr) |
                        (i_ex_rt_addr == i_id_rt_addr);
   assign o_hazard    = i_ex_valid & i_ex_mem_read & dst_nonzero & addr_match;

endmodule

// File: rtl/mod_id_ex_register.sv
// -----------------------------------------------------------------------------
// mod_id_ex_register
// ID/EX pipeline register. Latches the decode control word, operands,
// immediate, PC and register addresses, and presents the control word to EX
// as named slices. Also raises the combinational load-use hazard that stalls
// PC/IF-ID and nulls the control unit.
// Ports:
//   i_clock, i_reset (async, active low)
//   i_enable   0 freezes all state (debug step)
//   i_flush    taken branch/jump in EX: next entry is a bubble
//   i_control, i_valid, i_pc, i_rs_data, i_rt_data, i_imm, i_shamt,
//   i_rs_addr, i_rt_addr, i_rd_addr   decode-stage inputs
//   o_hazard   combinational load-use hazard
//   o_valid and registered copies of all fields; control bits as slices
// Valid semantics: o_valid=1 marks the EX slot as a real instruction; a slot
// with o_valid=0 always carries an all-zero control word, so it can never
// write state or raise a hazard.
// -----------------------------------------------------------------------------
module mod_id_ex_register
   import mod_id_ex_register_pkg::*;
#(
   parameter int NB_DATA    = 32,
   parameter int NB_ADDR    = 5,
   parameter int NB_CONTROL = 18
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_flush,
   input  logic [NB_CONTROL-1:0] i_control,
   input  logic                  i_valid,
   input  logic [NB_DATA-1:0]    i_pc,
   input  logic [NB_DATA-1:0]    i_rs_data,
   input  logic [NB_DATA-1:0]    i_rt_data,
   input  logic [NB_DATA-1:0]    i_imm,
   input  logic [4:0]            i_shamt,
   input  logic [NB_ADDR-1:0]    i_rs_addr,
   input  logic [NB_ADDR-1:0]    i_rt_addr,
   input  logic [NB_ADDR-1:0]    i_rd_addr,
   output logic                  o_hazard,
   output logic                  o_valid,
   output logic [NB_DATA-1:0]    o_pc,
   output logic [NB_DATA-1:0]    o_rs_data,
   output logic [NB_DATA-1:0]    o_rt_data,
   output logic [NB_DATA-1:0]    o_imm,
   output logic [4:0]            o_shamt,
   output logic [NB_ADDR-1:0]    o_rs_addr,
   output logic [NB_ADDR-1:0]    o_rt_addr,
   output logic [NB_ADDR-1:0]    o_rd_addr,
   output logic                  o_reg_dst,
   output logic                  o_mem_to_reg,
   output logic                  o_mem_read,
   output logic                  o_branch,
   output logic                  o_mem_write,
   output logic [NB_ALU_OP-1:0]  o_alu_op,
   output logic                  o_alu_src,
   output logic                  o_reg_write,
   output logic                  o_shift_src,
   output logic                  o_jmp_src,
   output logic                  o_jreturn_dst,
   output logic                  o_eq_or_ne,
   output logic [NB_MASK-1:0]    o_data_mask,
   output logic                  o_is_unsigned,
   output logic                  o_jmp_or_brch
);

   logic [NB_CONTROL-1:0] ctrl_q;
   logic                  bubble;

   mod_hazard_detect #(
      .NB_ADDR (NB_ADDR)
   ) u_hazard (
      .i_ex_valid    (o_valid),
      .i_ex_mem_read (o_mem_read),
      .i_ex_rt_addr  (o_rt_addr),
      .i_id_rs_addr  (i_rs_addr),
      .i_id_rt_addr  (i_rt_addr),
      .o_hazard      (o_hazard)
   );

   // Flush and hazard produce the same bubble; flush simply also covers it
   assign bubble = i_flush | o_hazard;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         ctrl_q    <= NB_CONTROL'(BUBBLE);
         o_valid   <= 1'b0;
         o_pc      <= '0;
         o_rs_data <= '0;
         o_rt_data <= '0;
         o_imm     <= '0;
         o_shamt   <= '0;
         o_rs_addr <= '0;
         o_rt_addr <= '0;
         o_rd_addr <= '0;
      end else if (i_enable) begin
         if (bubble) begin
            ctrl_q    <= NB_CONTROL'(BUBBLE);
            o_valid   <= 1'b0;
            o_pc      <= '0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm     <= '0;
            o_shamt   <= '0;
            o_rs_addr <= '0;
            o_rt_addr <= '0;
            o_rd_addr <= '0;
         end else begin
            // An empty decode slot must not carry live control bits
            ctrl_q    <= i_valid ? i_control : NB_CONTROL'(BUBBLE);
            o_valid   <= i_valid;
            o_pc      <= i_pc;
            o_rs_data <= i_rs_data;
            o_rt_data <= i_rt_data;
            o_imm     <= i_imm;
            o_shamt   <= i_shamt;
            o_rs_addr <= i_rs_addr;
            o_rt_addr <= i_rt_addr;
            o_rd_addr <= i_rd_addr;
         end
      end
   end

   assign o_reg_dst     = ctrl_q[CTRL_REG_DST];
   assign o_mem_to_reg  = ctrl_q[CTRL_MEM_TO_REG];
   assign o_mem_read    = ctrl_q[CTRL_MEM_READ];
   assign o_branch      = ctrl_q[CTRL_BRANCH];
   assign o_mem_write   = ctrl_q[CTRL_MEM_WRITE];
   assign o_alu_op      = ctrl_q[CTRL_ALU_OP_HI -: NB_ALU_OP];
   assign o_alu_src     = ctrl_q[CTRL_ALU_SRC];
   assign o_reg_write   = ctrl_q[CTRL_REG_WRITE];
   assign o_shift_src   = ctrl_q[CTRL_SHIFT_SRC];
   assign o_jmp_src     = ctrl_q[CTRL_JMP_SRC];
   assign o_jreturn_dst = ctrl_q[CTRL_JRETURN_DST];
   assign o_eq_or_ne    = ctrl_q[CTRL_EQ_OR_NE];
   assign o_data_mask   = ctrl_q[CTRL_DATA_MASK_HI -: NB_MASK];
   assign o_is_unsigned = ctrl_q[CTRL_IS_UNSIGNED];
   assign o_jmp_or_brch = ctrl_q[CTRL_JMP_OR_BRCH];

endmodule
